// File: rtl/mux4_scan_sequencer_pkg.sv
// mux4_scan_sequencer_pkg
// Shared definitions for the mux4 scan sequencer slice:
//   - state_t   : FSM state encoding (IDLE, SCAN, DONE)
//   - SEL_LAST  : last select value of a scan
//   - DATA_W    : width of the scanned word
//   - sel_bit() : the bit an ideal 4-to-1 mux returns for a word/select pair
package mux4_scan_sequencer_pkg;

    localparam int DATA_W = 4;
    localparam logic [1:0] SEL_LAST = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Reference bit of an ideal mux; the sampled bit is compared against this.
    function automatic logic sel_bit(input logic [DATA_W-1:0] word, input logic [1:0] sel);
        return word[sel];
    endfunction

endpackage

// File: rtl/mux4_scan_sequencer_if.sv
// mux4_scan_sequencer_if
// Bundles the word handshake, the mux drive/return path and the status lines.
//   in_data/in_valid/in_ready : word handshake (ready high only in IDLE)
//   mux_a/mux_sel/mux_b       : held word and select to the mux, mux output back
//   bit_out/bit_valid/done    : sampled bit stream and end-of-word pulse
//   err/err_clr               : sticky mismatch flag and its clear
// slave  : the sequencer's view.  master : the upstream/environment view.
interface mux4_scan_sequencer_if;
    import mux4_scan_sequencer_pkg::*;

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] mux_a;
    logic [1:0]        mux_sel;
    logic              mux_b;
    logic              bit_out;
    logic              bit_valid;
    logic              done;
    logic              err;
    logic              err_clr;

    modport slave (
        input  in_data, in_valid, mux_b, err_clr,
        output in_ready, mux_a, mux_sel, bit_out, bit_valid, done, err
    );

    modport master (
        output in_data, in_valid, mux_b, err_clr,
        input  in_ready, mux_a, mux_sel, bit_out, bit_valid, done, err
    );

endinterface

// File: rtl/mux4_scan_sequencer_dwell_counter.sv
// mux4_scan_sequencer_dwell_counter
// Up-counter with synchronous clear and terminal-count flag.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : force count to zero (wins over en)
//   en         : count up by one
//   tc         : count equals TERMINAL
module mux4_scan_sequencer_dwell_counter #(
    parameter int WIDTH    = 8,
    parameter int TERMINAL = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] cnt_r;

    // Count register: reset, then clear, then increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en) begin
            cnt_r <= cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tc = (cnt_r == TC_VAL);

endmodule

// File: rtl/mux4_scan_sequencer.sv
// mux4_scan_sequencer
// Accepts a 4-bit word, holds it on the mux data input and steps the select
// 0..3, dwelling DWELL cycles per slot. At the end of each dwell the mux output
// is sampled onto bit_out (LSB first) and compared against the held word.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave view of mux4_scan_sequencer_if (handshake, mux, status)
module mux4_scan_sequencer
    import mux4_scan_sequencer_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    mux4_scan_sequencer_if.slave bus
);

    state_t            state_r, state_nxt_s;
    logic [DATA_W-1:0] mux_a_r, mux_a_nxt_s;
    logic [1:0]        mux_sel_r, mux_sel_nxt_s;
    logic              bit_out_r, bit_out_nxt_s;
    logic              bit_valid_r, bit_valid_nxt_s;
    logic              done_r, done_nxt_s;
    logic              err_r, err_nxt_s;
    logic              err_set_s;
    logic              cnt_clr_s, cnt_en_s, cnt_tc_s;

    mux4_scan_sequencer_dwell_counter #(
        .WIDTH    (CNT_W),
        .TERMINAL (DWELL - 1)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr_s),
        .en    (cnt_en_s),
        .tc    (cnt_tc_s)
    );

    // Next-state and next-output logic for the scan FSM.
    always_comb begin
        state_nxt_s     = state_r;
        mux_a_nxt_s     = mux_a_r;
        mux_sel_nxt_s   = mux_sel_r;
        bit_out_nxt_s   = bit_out_r;
        bit_valid_nxt_s = 1'b0;
        done_nxt_s      = 1'b0;
        err_set_s       = 1'b0;
        cnt_clr_s       = 1'b0;
        cnt_en_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    mux_a_nxt_s   = bus.in_data;
                    mux_sel_nxt_s = 2'd0;
                    cnt_clr_s     = 1'b1;
                    state_nxt_s   = SCAN;
                end else begin
                    state_nxt_s   = IDLE;
                end
            end
            SCAN: begin
                cnt_en_s = 1'b1;
                if (cnt_tc_s) begin
                    bit_out_nxt_s   = bus.mux_b;
                    bit_valid_nxt_s = 1'b1;
                    err_set_s       = (bus.mux_b != sel_bit(mux_a_r, mux_sel_r));
                    // Clearing on every terminal count also covers the last slot;
                    // the count is not observed again until the next accept.
                    cnt_clr_s       = 1'b1;
                    if (mux_sel_r == SEL_LAST) begin
                        state_nxt_s   = DONE;
                    end else begin
                        mux_sel_nxt_s = mux_sel_r + 2'd1;
                        state_nxt_s   = SCAN;
                    end
                end else begin
                    state_nxt_s = SCAN;
                end
            end
            DONE: begin
                // done is registered, so it appears the cycle after DONE and
                // can never overlap the last bit_valid pulse.
                done_nxt_s    = 1'b1;
                mux_sel_nxt_s = 2'd0;
                state_nxt_s   = IDLE;
            end
            default: begin
                mux_sel_nxt_s = 2'd0;
                state_nxt_s   = IDLE;
            end
        endcase
        // Set beats clear when both happen in the same cycle.
        err_nxt_s = err_set_s | (err_r & ~bus.err_clr);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            mux_a_r     <= '0;
            mux_sel_r   <= 2'd0;
            bit_out_r   <= 1'b0;
            bit_valid_r <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            mux_a_r     <= mux_a_nxt_s;
            mux_sel_r   <= mux_sel_nxt_s;
            bit_out_r   <= bit_out_nxt_s;
            bit_valid_r <= bit_valid_nxt_s;
            done_r      <= done_nxt_s;
            err_r       <= err_nxt_s;
        end
    end

    assign bus.in_ready  = (state_r == IDLE);
    assign bus.mux_a     = mux_a_r;
    assign bus.mux_sel   = mux_sel_r;
    assign bus.bit_out   = bit_out_r;
    assign bus.bit_valid = bit_valid_r;
    assign bus.done      = done_r;
    assign bus.err       = err_r;

endmodule

// File: tb/tb_mux4_scan_sequencer.sv
// tb_mux4_scan_sequencer
// Drives two sequencers (DWELL=4 and DWELL=1) from shared stimulus, with a
// behavioural mux (ideal or stuck-at-0) on each. Expected outputs come from a
// timeline model: position in a word is the number of edges since accept.
module tb_mux4_scan_sequencer;
    import mux4_scan_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] td = 4'd0;
    logic       tv = 1'b0;
    logic       tgt = 1'b0;     // 0: DWELL=4 unit receives in_valid, 1: DWELL=1 unit
    logic       fault = 1'b0;   // mux output stuck at 0
    logic       clr = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    mux4_scan_sequencer_if bus4();
    mux4_scan_sequencer_if bus1();

    assign bus4.in_data  = td;
    assign bus4.in_valid = tv & ~tgt;
    assign bus4.err_clr  = clr;
    assign bus4.mux_b    = fault ? 1'b0 : bus4.mux_a[bus4.mux_sel];

    assign bus1.in_data  = td;
    assign bus1.in_valid = tv & tgt;
    assign bus1.err_clr  = clr;
    assign bus1.mux_b    = fault ? 1'b0 : bus1.mux_a[bus1.mux_sel];

    mux4_scan_sequencer #(.DWELL(4), .CNT_W(8)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    mux4_scan_sequencer #(.DWELL(1), .CNT_W(8)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    always #5 clk = ~clk;

    // Reference model state per unit (index 0: DWELL=4, index 1: DWELL=1).
    bit         busy[2];
    int         t[2];
    logic [3:0] word[2];
    logic       e_err[2];
    logic       e_bv[2];
    logic       e_bit[2];
    logic       e_done[2];

    function automatic int dwell_of(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic logic [1:0] exp_sel(input int d);
        int slot;
        if (!busy[d]) return 2'd0;
        slot = t[d] / dwell_of(d);
        return (slot > 3) ? 2'd3 : 2'(slot);
    endfunction

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            int  dw;
            logic vin, smp, set;
            dw  = dwell_of(d);
            vin = tv & ((d == 0) ? ~tgt : tgt);
            if (!rst_n) begin
                busy[d] = 1'b0; t[d] = 0; word[d] = 4'd0;
                e_err[d] = 1'b0; e_bv[d] = 1'b0; e_bit[d] = 1'b0; e_done[d] = 1'b0;
            end else begin
                set = 1'b0;
                e_bv[d] = 1'b0;
                e_done[d] = 1'b0;
                if (!busy[d]) begin
                    if (vin) begin
                        busy[d] = 1'b1; t[d] = 0; word[d] = td;
                    end
                end else begin
                    t[d] = t[d] + 1;
                    if ((t[d] % dw == 0) && (t[d] <= 4 * dw)) begin
                        smp = fault ? 1'b0 : word[d][t[d] / dw - 1];
                        e_bv[d] = 1'b1;
                        e_bit[d] = smp;
                        if (smp != word[d][t[d] / dw - 1]) set = 1'b1;
                    end else if (t[d] == 4 * dw + 1) begin
                        busy[d] = 1'b0;
                        e_done[d] = 1'b1;
                    end
                end
                e_err[d] = set | (e_err[d] & ~clr);
            end
        end
    endtask

    task automatic compare_all();
        check_val("rdy_d4",  8'(bus4.in_ready),  8'(!busy[0]));
        check_val("muxa_d4", 8'(bus4.mux_a),     8'(word[0]));
        check_val("sel_d4",  8'(bus4.mux_sel),   8'(exp_sel(0)));
        check_val("bv_d4",   8'(bus4.bit_valid), 8'(e_bv[0]));
        check_val("bit_d4",  8'(bus4.bit_out),   8'(e_bit[0]));
        check_val("done_d4", 8'(bus4.done),      8'(e_done[0]));
        check_val("err_d4",  8'(bus4.err),       8'(e_err[0]));
        check_val("rdy_d1",  8'(bus1.in_ready),  8'(!busy[1]));
        check_val("muxa_d1", 8'(bus1.mux_a),     8'(word[1]));
        check_val("sel_d1",  8'(bus1.mux_sel),   8'(exp_sel(1)));
        check_val("bv_d1",   8'(bus1.bit_valid), 8'(e_bv[1]));
        check_val("bit_d1",  8'(bus1.bit_out),   8'(e_bit[1]));
        check_val("done_d1", 8'(bus1.done),      8'(e_done[1]));
        check_val("err_d1",  8'(bus1.err),       8'(e_err[1]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        // Reset, then idle.
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();

        // Single word 4'b1011 on DWELL=4, ideal mux.
        tgt = 1'b0; td = 4'b1011; tv = 1'b1;
        step();
        tv = 1'b0;
        repeat (20) step();

        // Back-to-back 4'hA then 4'h5 with in_valid held high.
        td = 4'hA; tv = 1'b1;
        repeat (18) step();
        td = 4'h5;
        step();
        tv = 1'b0;
        repeat (20) step();

        // Stuck-at-0 mux, word 4'hF; clear coincident with a mismatch, then alone.
        fault = 1'b1; td = 4'hF; tv = 1'b1;
        step();
        tv = 1'b0;
        repeat (7) step();
        clr = 1'b1; step();
        clr = 1'b0; step();
        clr = 1'b1; step();
        clr = 1'b0;
        repeat (10) step();
        fault = 1'b0;
        clr = 1'b1; step();
        clr = 1'b0; step();

        // Reset mid-scan right after the 2nd bit_valid.
        td = 4'($urandom); tv = 1'b1;
        step();
        tv = 1'b0;
        repeat (8) step();
        rst_n = 1'b0; step();
        rst_n = 1'b1;
        repeat (20) step();

        // DWELL=1 unit, word 4'b0110.
        tgt = 1'b1; td = 4'b0110; tv = 1'b1;
        step();
        tv = 1'b0;
        repeat (8) step();

        // Randomised traffic on both units.
        for (int i = 0; i < 800; i++) begin
            tgt   = 1'($urandom_range(0, 1));
            tv    = ($urandom_range(0, 3) == 0);
            td    = 4'($urandom);
            clr   = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) fault = ~fault;
            rst_n = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
